// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush bundle between an instruction issuer and the register scoreboard.
// The issuer drives requests on the master side; the scoreboard answers on the slave side.
interface reg_scoreboard_if #(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int MAX_PENDING         = 4
);
   localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;
   localparam int CNT_W    = $clog2(MAX_PENDING + 1);

   logic                           issue_valid;
   logic                           issue_wrt_en;
   logic [REG_INDEX_BIT_WIDTH-1:0] issue_rd;
   logic [REG_INDEX_BIT_WIDTH-1:0] issue_rs1;
   logic [REG_INDEX_BIT_WIDTH-1:0] issue_rs2;
   logic                           wb_valid;
   logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd;
   logic                           flush;
   logic                           stall;
   logic                           issue_accept;
   logic [NUM_REGS-1:0]            busy_vec;
   logic [CNT_W-1:0]               pending_cnt;
   logic                           err_spurious_wb;

   modport master (
      output issue_valid, issue_wrt_en, issue_rd, issue_rs1, issue_rs2,
      output wb_valid, wb_rd, flush,
      input  stall, issue_accept, busy_vec, pending_cnt, err_spurious_wb
   );

   modport slave (
      input  issue_valid, issue_wrt_en, issue_rd, issue_rs1, issue_rs2,
      input  wb_valid, wb_rd, flush,
      output stall, issue_accept, busy_vec, pending_cnt, err_spurious_wb
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks destination registers with writes in flight and stalls
// issue on RAW/WAW hazards or when the number of outstanding writes reaches MAX_PENDING.
module reg_scoreboard #(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int MAX_PENDING         = 4
) (
   input logic             clk,
   input logic             reset,
   reg_scoreboard_if.slave sb
);
   localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;
   localparam int CNT_W    = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                stall, accept, set_en, clr_en;

   always_comb begin
      // Hazards are judged on registered state only; a same-cycle writeback does not bypass.
      stall  = sb.issue_valid &
               (busy_q[sb.issue_rs1] | busy_q[sb.issue_rs2] |
                (sb.issue_wrt_en & (busy_q[sb.issue_rd] | (cnt_q == MAX_CNT))));
      accept = sb.issue_valid & ~stall & ~sb.flush;
      set_en = accept & sb.issue_wrt_en;
      clr_en = sb.wb_valid & busy_q[sb.wb_rd];

      busy_d = busy_q;
      cnt_d  = cnt_q;
      err_d  = 1'b0;

      if (sb.flush) begin
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         if (clr_en) busy_d[sb.wb_rd] = 1'b0;
         if (set_en) busy_d[sb.issue_rd] = 1'b1;
         // Set and clear together (same or different register) leave the count unchanged.
         if (set_en && !clr_en && cnt_q != MAX_CNT)
            cnt_d = cnt_q + CNT_W'(1);
         else if (clr_en && !set_en && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
         err_d = sb.wb_valid & ~busy_q[sb.wb_rd];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign sb.stall           = stall;
   assign sb.issue_accept    = accept;
   assign sb.busy_vec        = busy_q;
   assign sb.pending_cnt     = cnt_q;
   assign sb.err_spurious_wb = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed step tables plus a randomized run,
// expected post-edge state queued at drive time and popped after the clock edge.
module tb_reg_scoreboard;
   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic       w;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic       wbv;
      logic [3:0] wbrd;
      logic       fl;
      logic       stall;
      logic       acc;
      logic [15:0] busy;
      logic [2:0] cnt;
      logic       err;
   } step_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [19:0] exp_q [$];

   reg_scoreboard_if #(.REG_INDEX_BIT_WIDTH(4), .MAX_PENDING(4)) bus ();

   reg_scoreboard #(.REG_INDEX_BIT_WIDTH(4), .MAX_PENDING(4)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive(input step_t s);
      reset            = s.rst;
      bus.issue_valid  = s.v;
      bus.issue_wrt_en = s.w;
      bus.issue_rd     = s.rd;
      bus.issue_rs1    = s.rs1;
      bus.issue_rs2    = s.rs2;
      bus.wb_valid     = s.wbv;
      bus.wb_rd        = s.wbrd;
      bus.flush        = s.fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t s [2];
      logic [19:0] e;
      s = '{
         '{Y,N,N,4'd0,4'd0,4'd0,N,4'd0,N, N,N, 16'h0000,3'd0,N},
         '{N,N,N,4'd0,4'd0,4'd0,N,4'd0,N, N,N, 16'h0000,3'd0,N}
      };
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {s[i].stall, s[i].acc}) begin
            errors++;
            $display("FAIL reset[%0d] stall/accept: got %b%b expected %b%b", i,
                     bus.stall, bus.issue_accept, s[i].stall, s[i].acc);
         end
         exp_q.push_back({s[i].busy, s[i].cnt, s[i].err});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL reset[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     i, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   task automatic test_hazard();
      step_t s [8];
      logic [19:0] e;
      s = '{
         '{N,Y,Y,4'd3,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0008,3'd1,N},
         '{N,Y,Y,4'd3,4'd0,4'd0,N,4'd0,N, Y,N, 16'h0008,3'd1,N},
         '{N,Y,N,4'd0,4'd3,4'd0,N,4'd0,N, Y,N, 16'h0008,3'd1,N},
         '{N,Y,N,4'd0,4'd3,4'd0,Y,4'd3,N, Y,N, 16'h0000,3'd0,N},
         '{N,Y,N,4'd0,4'd3,4'd0,N,4'd0,N, N,Y, 16'h0000,3'd0,N},
         '{N,Y,Y,4'd0,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0001,3'd1,N},
         '{N,Y,N,4'd5,4'd5,4'd0,N,4'd0,N, Y,N, 16'h0001,3'd1,N},
         '{N,N,N,4'd0,4'd0,4'd0,Y,4'd0,N, N,N, 16'h0000,3'd0,N}
      };
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {s[i].stall, s[i].acc}) begin
            errors++;
            $display("FAIL hazard[%0d] stall/accept: got %b%b expected %b%b", i,
                     bus.stall, bus.issue_accept, s[i].stall, s[i].acc);
         end
         exp_q.push_back({s[i].busy, s[i].cnt, s[i].err});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL hazard[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     i, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   task automatic test_capacity();
      step_t s [12];
      logic [19:0] e;
      s = '{
         '{N,Y,Y,4'd1,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0002,3'd1,N},
         '{N,Y,Y,4'd2,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0006,3'd2,N},
         '{N,Y,Y,4'd4,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0016,3'd3,N},
         '{N,Y,Y,4'd5,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0036,3'd4,N},
         '{N,Y,Y,4'd6,4'd0,4'd0,N,4'd0,N, Y,N, 16'h0036,3'd4,N},
         '{N,Y,N,4'd6,4'd7,4'd8,N,4'd0,N, N,Y, 16'h0036,3'd4,N},
         '{N,Y,Y,4'd6,4'd0,4'd0,Y,4'd1,N, Y,N, 16'h0034,3'd3,N},
         '{N,Y,Y,4'd6,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0074,3'd4,N},
         '{N,N,N,4'd0,4'd0,4'd0,Y,4'd4,N, N,N, 16'h0064,3'd3,N},
         '{N,Y,Y,4'd7,4'd0,4'd0,Y,4'd2,N, N,Y, 16'h00E0,3'd3,N},
         '{N,N,N,4'd0,4'd0,4'd0,Y,4'd9,N, N,N, 16'h00E0,3'd3,Y},
         '{N,N,N,4'd0,4'd0,4'd0,N,4'd0,N, N,N, 16'h00E0,3'd3,N}
      };
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {s[i].stall, s[i].acc}) begin
            errors++;
            $display("FAIL capacity[%0d] stall/accept: got %b%b expected %b%b", i,
                     bus.stall, bus.issue_accept, s[i].stall, s[i].acc);
         end
         exp_q.push_back({s[i].busy, s[i].cnt, s[i].err});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL capacity[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     i, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   // Entered with r5, r6, r7 pending from test_capacity.
   task automatic test_flush();
      step_t s [3];
      logic [19:0] e;
      s = '{
         '{N,Y,Y,4'd8,4'd0,4'd0,Y,4'd9,Y, N,N, 16'h0000,3'd0,N},
         '{N,N,N,4'd0,4'd0,4'd0,Y,4'd5,N, N,N, 16'h0000,3'd0,Y},
         '{N,N,N,4'd0,4'd0,4'd0,N,4'd0,N, N,N, 16'h0000,3'd0,N}
      };
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {s[i].stall, s[i].acc}) begin
            errors++;
            $display("FAIL flush[%0d] stall/accept: got %b%b expected %b%b", i,
                     bus.stall, bus.issue_accept, s[i].stall, s[i].acc);
         end
         exp_q.push_back({s[i].busy, s[i].cnt, s[i].err});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL flush[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     i, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      step_t s [5];
      logic [19:0] e;
      s = '{
         '{N,Y,Y,4'd1,4'd0,4'd0,N,4'd0,N, N,Y, 16'h0002,3'd1,N},
         '{N,Y,Y,4'd2,4'd0,4'd0,Y,4'd9,N, N,Y, 16'h0006,3'd2,Y},
         '{Y,Y,Y,4'd3,4'd1,4'd0,Y,4'd9,N, Y,N, 16'h0000,3'd0,N},
         '{Y,Y,Y,4'd3,4'd0,4'd0,Y,4'd9,N, N,Y, 16'h0000,3'd0,N},
         '{N,N,N,4'd0,4'd0,4'd0,N,4'd0,N, N,N, 16'h0000,3'd0,N}
      };
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {s[i].stall, s[i].acc}) begin
            errors++;
            $display("FAIL reset_mid[%0d] stall/accept: got %b%b expected %b%b", i,
                     bus.stall, bus.issue_accept, s[i].stall, s[i].acc);
         end
         exp_q.push_back({s[i].busy, s[i].cnt, s[i].err});
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL reset_mid[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     i, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   // Randomized traffic against a behavioural model; entered from an all-idle state.
   task automatic test_back_to_back();
      step_t       s;
      logic [15:0] mb, nb;
      logic        me;
      int          mc;
      logic        ms, ma;
      logic [19:0] e;
      mb = '0;
      me = 1'b0;
      for (int n = 0; n < 400; n++) begin
         s      = '0;
         s.rst  = ($urandom_range(0, 63) == 0);
         s.v    = $urandom_range(0, 1) == 1;
         s.w    = $urandom_range(0, 3) != 0;
         s.rd   = 4'($urandom_range(0, 7));
         s.rs1  = 4'($urandom_range(0, 15));
         s.rs2  = 4'($urandom_range(0, 15));
         s.wbv  = $urandom_range(0, 1) == 1;
         s.wbrd = 4'($urandom_range(0, 8));
         s.fl   = ($urandom_range(0, 31) == 0);
         mc     = $countones(mb);
         ms     = s.v & (mb[s.rs1] | mb[s.rs2] | (s.w & mb[s.rd]) | (s.w & (mc == 4)));
         ma     = s.v & ~ms & ~s.fl;
         if (s.rst || s.fl) begin
            nb = '0;
            me = 1'b0;
         end else begin
            nb = mb;
            me = s.wbv & ~mb[s.wbrd];
            if (s.wbv && mb[s.wbrd]) nb[s.wbrd] = 1'b0;
            if (ma && s.w) nb[s.rd] = 1'b1;
         end
         drive(s);
         checks++;
         if ({bus.stall, bus.issue_accept} !== {ms, ma}) begin
            errors++;
            $display("FAIL random[%0d] stall/accept: got %b%b expected %b%b", n,
                     bus.stall, bus.issue_accept, ms, ma);
         end
         exp_q.push_back({nb, 3'($countones(nb)), me});
         mb = nb;
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb} !== e) begin
            errors++;
            $display("FAIL random[%0d] state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                     n, bus.busy_vec, bus.pending_cnt, bus.err_spurious_wb, e[19:4], e[3:1], e[0]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_hazard();
      test_capacity();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The module SHALL take parameter REG_INDEX_BIT_WIDTH, default 4, giving the register index width; NUM_REGS = 2**REG_INDEX_BIT_WIDTH.
REQ-002 The module SHALL take parameter MAX_PENDING, default 4, giving the maximum number of outstanding register writes (1..NUM_REGS).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 issue_valid  input  1  an instruction is presented for issue this cycle.
REQ-006 issue_wrt_en  input  1  the presented instruction writes a register.
REQ-007 issue_rd, issue_rs1, issue_rs2  input  REG_INDEX_BIT_WIDTH each  destination and source indices of the presented instruction.
REQ-008 wb_valid  input  1  a writeback completes this cycle.
REQ-009 wb_rd  input  REG_INDEX_BIT_WIDTH  register being written back.
REQ-010 flush  input  1  discard all pending-write tracking.
REQ-011 stall  output  1  the presented instruction is not accepted this cycle.
REQ-012 issue_accept  output  1  the presented instruction is accepted this cycle.
REQ-013 busy_vec  output  NUM_REGS  bit i set = register i has a pending write.
REQ-014 pending_cnt  output  clog2(MAX_PENDING+1)  number of set busy bits.
REQ-015 err_spurious_wb  output  1  registered one-cycle pulse: a writeback targeted a non-busy register.

Function
REQ-016 stall SHALL be combinational from current registered state and inputs: issue_valid AND (busy[rs1] OR busy[rs2] OR (issue_wrt_en AND busy[rd]) OR (issue_wrt_en AND pending_cnt == MAX_PENDING)).
REQ-017 stall SHALL NOT use same-cycle writeback bypass; a register cleared by wb_valid this cycle is still seen busy until the next cycle.
REQ-018 issue_accept SHALL equal issue_valid AND NOT stall AND NOT flush.
REQ-019 On issue_accept with issue_wrt_en, busy[issue_rd] SHALL be set at the next edge.
REQ-020 On issue_accept without issue_wrt_en, no busy bit and no count SHALL change.
REQ-021 On wb_valid with busy[wb_rd] set, busy[wb_rd] SHALL clear at the next edge.
REQ-022 On wb_valid with busy[wb_rd] clear, state SHALL be unchanged and err_spurious_wb SHALL be 1 in the following cycle only.
REQ-023 pending_cnt next SHALL = pending_cnt + (set occurs) - (clear occurs); simultaneous set and clear of different registers SHALL leave the count unchanged.
REQ-024 Set and clear of the same register in one cycle is unreachable (rd busy stalls); if forced, the set SHALL win and the count SHALL stay unchanged.
REQ-025 pending_cnt SHALL never exceed MAX_PENDING nor wrap below 0.
REQ-026 flush SHALL clear busy_vec and pending_cnt at the next edge, override same-cycle issue and writeback, and suppress err_spurious_wb for that cycle.
REQ-027 Writebacks arriving after a flush for previously busy registers SHALL raise err_spurious_wb.
REQ-028 Register 0 SHALL be tracked like any other register.

Reset
REQ-029 While reset is high at a clock edge, busy_vec SHALL become all zeros, pending_cnt SHALL become 0, and err_spurious_wb SHALL become 0.
REQ-030 Reset SHALL take priority over flush, issue and writeback, including mid-operation with pending writes.
REQ-031 In the reset cycle stall and issue_accept SHALL still follow REQ-016/REQ-018 from the pre-reset registered state; no state update SHALL result.

Verification
REQ-032 Reset, then issue rd=3 write: issue_accept=1 -> next cycle busy_vec=0x0008, pending_cnt=1; issue rs1=3 -> stall=1.
REQ-033 With busy[3] set, wb_valid rd=3 together with issue rs1=3 -> stall=1 that cycle; next cycle busy_vec=0, and the reissue is accepted.
REQ-034 Issue writes to r1,r2,r4,r5 (MAX_PENDING=4) -> pending_cnt=4; a write issue to r6 stalls; a non-writing issue with clear sources is accepted; wb r1 -> the r6 issue is accepted the next cycle with pending_cnt=4.
REQ-035 Same cycle: issue write r7 accepted plus wb r2 (busy) -> pending_cnt unchanged, busy[7]=1, busy[2]=0.
REQ-036 wb_valid rd=9 while not busy -> err_spurious_wb=1 for exactly one cycle, busy_vec unchanged.
REQ-037 With 3 pending, assert flush with issue_valid -> issue_accept=0, next cycle busy_vec=0, pending_cnt=0; a following wb to a previously busy register -> err_spurious_wb pulse; reset asserted with pending writes -> all outputs cleared next cycle.
